// File: rtl/pc_pkg.sv
// Shared types, widths and helpers for the program-counter / run-control stage.
package pc_pkg;

    // Run-control states of the core.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    // Default widths of the program counter and of the relative branch offset.
    localparam int PC_W  = 10;
    localparam int OFS_W = 8;

    // Sign-extend a relative branch offset to program-counter width so the
    // branch add can be done as a plain modulo-2^PC_W addition.
    function automatic logic [PC_W-1:0] sign_ext(input logic [OFS_W-1:0] ofs);
        return {{(PC_W-OFS_W){ofs[OFS_W-1]}}, ofs};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold, absolute jump, relative branch or increment.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int PC_W  = pc_pkg::PC_W,
    parameter int OFS_W = pc_pkg::OFS_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             halt,
    input  logic             stall,
    input  logic             abs_jump,
    input  logic [PC_W-1:0]  target,
    input  logic             branch_taken,
    input  logic [OFS_W-1:0] rel_ofs,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] ofs_ext;

    // Package helper covers the default widths; other widths extend inline.
    generate
        if (PC_W == pc_pkg::PC_W && OFS_W == pc_pkg::OFS_W) begin : g_pkg_ext
            assign ofs_ext = sign_ext(rel_ofs);
        end else begin : g_inline_ext
            assign ofs_ext = {{(PC_W-OFS_W){rel_ofs[OFS_W-1]}}, rel_ofs};
        end
    endgenerate

    // Priority mux: halt and stall both freeze the PC, jump beats branch.
    always_comb begin
        next_pc = pc + 1'b1;
        if (halt || stall) begin
            next_pc = pc;
        end else if (abs_jump) begin
            next_pc = target;
        end else if (branch_taken) begin
            next_pc = pc + ofs_ext;
        end
    end

endmodule

// File: rtl/prog_ctr_fsm.sv
// Program counter, run/done handshake and saturating RUN-cycle counter.
module prog_ctr_fsm
    import pc_pkg::*;
#(
    parameter int              PC_W       = pc_pkg::PC_W,
    parameter int              OFS_W      = pc_pkg::OFS_W,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              AbsJump,
    input  logic [PC_W-1:0]   Target,
    input  logic              BranchTaken,
    input  logic [OFS_W-1:0]  RelOfs,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCnt
);

    run_state_t      state_reg;
    logic [PC_W-1:0] next_pc;

    pc_next_sel #(
        .PC_W  (PC_W),
        .OFS_W (OFS_W)
    ) u_next_sel (
        .pc           (ProgCtr),
        .halt         (Halt),
        .stall        (Stall),
        .abs_jump     (AbsJump),
        .target       (Target),
        .branch_taken (BranchTaken),
        .rel_ofs      (RelOfs),
        .next_pc      (next_pc)
    );

    // Run-control FSM with registered PC, counter and status flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            ProgCtr   <= START_ADDR;
            Running   <= 1'b0;
            Done      <= 1'b0;
            CycleCnt  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // A new program may start from idle or straight after the previous one.
                    if (Start) begin
                        state_reg <= RUN;
                        ProgCtr   <= START_ADDR;
                        CycleCnt  <= '0;
                        Running   <= 1'b1;
                        Done      <= 1'b0;
                    end
                end
                RUN: begin
                    ProgCtr <= next_pc;
                    if (CycleCnt != {CNT_W{1'b1}}) begin
                        CycleCnt <= CycleCnt + 1'b1;
                    end
                    if (Halt) begin
                        state_reg <= DONE;
                        Running   <= 1'b0;
                        Done      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    Running   <= 1'b0;
                    Done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr_fsm.sv
// Self-checking bench for prog_ctr_fsm: directed scenarios plus randomized run
// traffic compared against an arithmetic reference model.
module tb_prog_ctr_fsm;

    localparam int PC_MOD  = 1024;
    localparam int CNT_MAX = 65535;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Halt;
    logic       Stall;
    logic       AbsJump;
    logic [9:0] Target;
    logic       BranchTaken;
    logic [7:0] RelOfs;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
    logic [15:0] CycleCnt;

    int checks;
    int errors;

    // Reference model: 0 = idle, 1 = running, 2 = finished.
    int m_mode;
    int m_pc;
    int m_cnt;

    prog_ctr_fsm dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Halt        (Halt),
        .Stall       (Stall),
        .AbsJump     (AbsJump),
        .Target      (Target),
        .BranchTaken (BranchTaken),
        .RelOfs      (RelOfs),
        .ProgCtr     (ProgCtr),
        .Running     (Running),
        .Done        (Done),
        .CycleCnt    (CycleCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit verbose);
        if (verbose)
            $display("%-12s pc=%0d run=%0d done=%0d cnt=%0d", tag, ProgCtr, Running, Done, CycleCnt);
        check({tag, ".pc"}, int'(ProgCtr), m_pc);
        check({tag, ".run"}, int'(Running), (m_mode == 1) ? 1 : 0);
        check({tag, ".done"}, int'(Done), (m_mode == 2) ? 1 : 0);
        check({tag, ".cnt"}, int'(CycleCnt), m_cnt);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    // One clock of the architectural rules, applied to the current inputs.
    task automatic model_step();
        int ofs;
        if (m_mode == 1) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            ofs = int'(RelOfs);
            if (ofs >= 128) ofs = ofs - 256;
            if (Halt)             m_mode = 2;
            else if (Stall)       m_pc = m_pc;
            else if (AbsJump)     m_pc = int'(Target);
            else if (BranchTaken) m_pc = ((m_pc + ofs) % PC_MOD + PC_MOD) % PC_MOD;
            else                  m_pc = (m_pc + 1) % PC_MOD;
        end else if (Start) begin
            m_mode = 1;
            m_pc   = 0;
            m_cnt  = 0;
        end
    endtask

    task automatic set_in(input bit st, input bit ht, input bit sl, input bit aj,
                          input int tg, input bit bt, input int ofs);
        Start       = st;
        Halt        = ht;
        Stall       = sl;
        AbsJump     = aj;
        Target      = 10'(tg);
        BranchTaken = bt;
        RelOfs      = 8'(ofs);
    endtask

    task automatic cycle(input string tag, input bit verbose);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag, verbose);
    endtask

    // Reset raised between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"}, 1'b1);
        @(posedge Clk);
        #1;
        check_all({tag, ".held"}, 1'b1);
        Reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset", 1'b1);
        Reset = 1'b0;
        cycle("idle", 1'b1);

        // Start then plain sequential execution.
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle("start", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("seq", 1'b1);

        // Absolute jump, alone and together with a branch.
        set_in(0, 0, 0, 1, 7, 0, 0);     cycle("to7", 1'b1);
        set_in(0, 0, 0, 1, 238, 0, 0);   cycle("jump238", 1'b1);
        set_in(0, 0, 0, 1, 7, 0, 0);     cycle("to7b", 1'b1);
        set_in(0, 0, 0, 1, 238, 1, 10);  cycle("jump_win", 1'b1);

        // Relative branches and wraparound.
        set_in(0, 0, 0, 1, 20, 0, 0);    cycle("to20", 1'b1);
        set_in(0, 0, 0, 0, 0, 1, -4);    cycle("br_m4", 1'b1);
        set_in(0, 0, 0, 1, 2, 0, 0);     cycle("to2", 1'b1);
        set_in(0, 0, 0, 0, 0, 1, -5);    cycle("br_m5", 1'b1);
        set_in(0, 0, 0, 1, 1023, 0, 0);  cycle("to1023", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);     cycle("wrap", 1'b1);

        // Stall, halt, frozen DONE ignoring redirects.
        set_in(0, 0, 0, 1, 50, 0, 0);    cycle("to50", 1'b1);
        set_in(0, 0, 1, 1, 99, 1, 3);
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1);
        set_in(0, 1, 0, 1, 77, 0, 0);    cycle("halt", 1'b1);
        set_in(0, 1, 1, 1, 300, 1, 9);
        for (int i = 0; i < 2; i++) cycle("frozen", 1'b1);

        // Restart from DONE, then Start pulsed mid-run.
        set_in(1, 0, 0, 0, 0, 0, 0);     cycle("restart", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);     cycle("seq2", 1'b1);
        set_in(1, 0, 0, 0, 0, 0, 0);     cycle("start_run", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);     cycle("seq3", 1'b1);

        // Asynchronous reset while running, then idle until Start.
        set_in(0, 0, 0, 1, 335, 0, 0);   cycle("to335", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        async_reset("rst_run");
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b1);

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 1023)),
                   ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 255)));
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            else cycle("rnd", 1'b1);
        end

        // Counter saturation over a long uninterrupted run.
        set_in(1, 0, 0, 0, 0, 0, 0);     cycle("sat_start", 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 4; i++) cycle("sat", 1'b0);
        check_all("saturated", 1'b1);
        set_in(0, 1, 0, 0, 0, 0, 0);     cycle("sat_halt", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_ctr_fsm.md
Name: prog_ctr_fsm

Overview:
- Program counter and run-control stage for the single-cycle core. It sits directly downstream of the branch-target lookup table.
- Each cycle it selects the next instruction address from four sources: sequential increment, the absolute jump target from the lookup table, a PC-relative branch, or hold.
- It drives the instruction memory address and the run/done handshake seen by the testbench.
- It also counts executed cycles for performance reporting.

Parameters:
- PC_W, 10, width of program counter and of absolute jump target.
- OFS_W, 8, width of signed relative branch offset.
- START_ADDR, 0, PC value loaded on Start.
- CNT_W, 16, width of the saturating cycle counter.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin program execution; sampled at rising edge.
- Halt  in  1  decoded halt instruction; ends the program.
- Stall  in  1  hold PC this cycle.
- AbsJump  in  1  take the absolute jump to Target.
- Target  in  PC_W  absolute address from the branch-target lookup table.
- BranchTaken  in  1  take the relative branch.
- RelOfs  in  OFS_W  signed two's-complement relative offset.
- ProgCtr  out  PC_W  current instruction address to instruction memory.
- Running  out  1  high while the FSM is in RUN; fetched instruction is valid.
- Done  out  1  high while the FSM is in DONE.
- CycleCnt  out  CNT_W  count of RUN cycles completed since the last Start.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0, CycleCnt=0.
- Reset asserted mid-run forces these values immediately. After reset deasserts, the block waits for a new Start.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 -> RUN, ProgCtr<=START_ADDR, CycleCnt<=0.
  - Otherwise hold.
- RUN, one decision per cycle, priority highest first:
  1. Halt=1 -> DONE; ProgCtr holds. CycleCnt increments for this final cycle.
  2. Stall=1 -> ProgCtr holds; CycleCnt increments.
  3. AbsJump=1 -> ProgCtr<=Target.
  4. BranchTaken=1 -> ProgCtr<=ProgCtr + sign_extend(RelOfs), computed modulo 2^PC_W.
  5. Otherwise -> ProgCtr<=ProgCtr+1, modulo 2^PC_W. Address 1023 wraps to 0.
- Start while in RUN is ignored.
- AbsJump and BranchTaken asserted together: AbsJump wins.
- In RUN, CycleCnt increments every cycle and saturates at 2^CNT_W-1; it does not wrap.
- DONE:
  - Done=1; ProgCtr and CycleCnt hold.
  - Start=1 -> RUN, ProgCtr<=START_ADDR, CycleCnt<=0. This allows back-to-back programs without reset.
- Running=1 exactly when state==RUN. Done=1 exactly when state==DONE. They are never both high.
- Latency: a redirect sampled in cycle N appears on ProgCtr in cycle N+1. There is no delay slot.
- Halt, Stall, AbsJump, BranchTaken and RelOfs are ignored outside RUN.
- Negative RelOfs that underflows below 0 wraps modulo 2^PC_W. Example: PC=2, RelOfs=-5 -> 1021.

Decomposition:
- Shared package pc_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} run_state_t;
  - localparams PC_W and OFS_W;
  - a sign-extension function for RelOfs.
- Natural sub-module: pc_next_sel. It is the combinational next-PC mux implementing the priority above, so the mux can be unit-tested in isolation.
- The FSM, PC register and counter stay in prog_ctr_fsm.

Test Plan:
- Reset then Start, no redirects, 5 cycles -> ProgCtr 0,1,2,3,4,5; Running=1; CycleCnt=5.
- In RUN at PC=7, AbsJump=1, Target=238 -> next ProgCtr=238. Repeat with BranchTaken=1, RelOfs=+10 also asserted -> still 238.
- PC=20, BranchTaken=1, RelOfs=-4 -> 16. PC=2, RelOfs=-5 -> 1021. PC=1023, sequential -> 0.
- PC=50, Stall=1 for 3 cycles -> ProgCtr stays 50 and CycleCnt advances by 3. Then Halt=1 -> Done=1, Running=0, ProgCtr=50, values frozen.
- From DONE, Start=1 -> ProgCtr=0, CycleCnt=0, Running=1 next cycle. Start pulsed mid-RUN -> no effect.
- Assert Reset asynchronously mid-cycle in RUN at PC=335 -> outputs go to reset values before the next clock edge. After release, PC stays 0 in IDLE until Start.
